// File: rtl/muntjac_pkg.sv
// Shared TileLink-UH definitions for the muntjac memory interconnect:
// A-channel opcodes and beat accounting helpers.
package muntjac_pkg;

  typedef enum logic [2:0] {
    TL_PUT_FULL      = 3'd0,
    TL_PUT_PARTIAL   = 3'd1,
    TL_ARITHMETIC    = 3'd2,
    TL_LOGICAL       = 3'd3,
    TL_GET           = 3'd4,
    TL_INTENT        = 3'd5,
    TL_ACQUIRE_BLOCK = 3'd6,
    TL_ACQUIRE_PERM  = 3'd7
  } tl_a_op_e;

  function automatic logic tl_a_has_data(input logic [2:0] opcode);
    case (tl_a_op_e'(opcode))
      TL_PUT_FULL, TL_PUT_PARTIAL, TL_ARITHMETIC, TL_LOGICAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Transfers no wider than one beat still occupy a full beat.
  function automatic int unsigned tl_num_beats(input int unsigned size,
                                               input int unsigned data_width);
    int unsigned beat_log;
    beat_log = $clog2(data_width / 32'd8);
    if (size <= beat_log) begin
      return 32'd1;
    end else begin
      return 32'd1 << (size - beat_log);
    end
  endfunction

endpackage

// File: rtl/muntjac_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester
// found scanning upward from ptr, wrapping modulo N.
module muntjac_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned IdxWidth = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [IdxWidth-1:0] grant_idx
);

  // Priority scan starting at ptr; the first hit suppresses later candidates.
  always_comb begin
    logic [IdxWidth-1:0] idx_s;
    logic                found_s;
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx_s = IdxWidth'((32'(ptr) + i) % N);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/muntjac_tl_a_arbiter.sv
// Round-robin arbiter sharing one TileLink-UH A channel among NumHosts
// requesters, locking the grant across stalled first beats and data bursts.
module muntjac_tl_a_arbiter
  import muntjac_pkg::*;
#(
  parameter int unsigned NumHosts    = 4,
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned SourceWidth = 4,
  parameter int unsigned SizeWidth   = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumHosts-1:0]                  host_valid_i,
  output logic [NumHosts-1:0]                  host_ready_o,
  input  logic [NumHosts-1:0][2:0]             host_opcode_i,
  input  logic [NumHosts-1:0][2:0]             host_param_i,
  input  logic [NumHosts-1:0][SizeWidth-1:0]   host_size_i,
  input  logic [NumHosts-1:0][SourceWidth-1:0] host_source_i,
  input  logic [NumHosts-1:0][AddrWidth-1:0]   host_address_i,
  input  logic [NumHosts-1:0][DataWidth/8-1:0] host_mask_i,
  input  logic [NumHosts-1:0][DataWidth-1:0]   host_data_i,
  output logic                                 dev_valid_o,
  input  logic                                 dev_ready_i,
  output logic [2:0]                           dev_opcode_o,
  output logic [2:0]                           dev_param_o,
  output logic [SizeWidth-1:0]                 dev_size_o,
  output logic [SourceWidth-1:0]               dev_source_o,
  output logic [AddrWidth-1:0]                 dev_address_o,
  output logic [DataWidth/8-1:0]               dev_mask_o,
  output logic [DataWidth-1:0]                 dev_data_o,
  output logic [NumHosts-1:0]                  grant_o
);

  localparam int unsigned PtrWidth  = $clog2(NumHosts);
  localparam int unsigned BeatWidth =
      $clog2((32'd1 << ((32'd1 << SizeWidth) - 32'd1)) / (DataWidth / 32'd8)) + 1;

  logic                 lock_r, lock_nxt_s;
  logic [BeatWidth-1:0] beats_left_r, beats_left_nxt_s;
  logic [PtrWidth-1:0]  ptr_r, ptr_nxt_s;
  logic [PtrWidth-1:0]  gidx_r, gidx_nxt_s;

  logic [NumHosts-1:0]  arb_grant_s;
  logic [PtrWidth-1:0]  arb_idx_s;
  logic [PtrWidth-1:0]  sel_idx_s;
  logic                 accept_s;
  logic [BeatWidth-1:0] total_beats_s;

  function automatic logic [PtrWidth-1:0] ptr_after(input logic [PtrWidth-1:0] idx);
    if (idx == PtrWidth'(NumHosts - 1)) begin
      return '0;
    end else begin
      return idx + PtrWidth'(1'b1);
    end
  endfunction

  muntjac_rr_arbiter #(
    .N        (NumHosts),
    .IdxWidth (PtrWidth)
  ) u_rr (
    .req       (host_valid_i),
    .ptr       (ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s)
  );

  // Grant selection and A-channel mux; the locked host keeps the channel even if it drops valid.
  always_comb begin
    if (lock_r) begin
      sel_idx_s   = gidx_r;
      grant_o     = {{(NumHosts-1){1'b0}}, 1'b1} << gidx_r;
      dev_valid_o = host_valid_i[gidx_r];
    end else begin
      sel_idx_s   = arb_idx_s;
      grant_o     = arb_grant_s;
      dev_valid_o = |host_valid_i;
    end
    host_ready_o  = grant_o & {NumHosts{dev_ready_i}};
    accept_s      = dev_valid_o & dev_ready_i;
    dev_opcode_o  = host_opcode_i[sel_idx_s];
    dev_param_o   = host_param_i[sel_idx_s];
    dev_size_o    = host_size_i[sel_idx_s];
    dev_source_o  = host_source_i[sel_idx_s];
    dev_address_o = host_address_i[sel_idx_s];
    dev_mask_o    = host_mask_i[sel_idx_s];
    dev_data_o    = host_data_i[sel_idx_s];
    if (tl_a_has_data(host_opcode_i[sel_idx_s])) begin
      total_beats_s = BeatWidth'(tl_num_beats(32'(host_size_i[sel_idx_s]), DataWidth));
    end else begin
      total_beats_s = BeatWidth'(1'b1);
    end
  end

  // Lock/counter/pointer next state: IDLE is !lock, HOLD/BURST are lock with beats remaining.
  always_comb begin
    lock_nxt_s       = lock_r;
    beats_left_nxt_s = beats_left_r;
    ptr_nxt_s        = ptr_r;
    gidx_nxt_s       = gidx_r;
    if (!lock_r) begin
      if (dev_valid_o && accept_s) begin
        if (total_beats_s == BeatWidth'(1'b1)) begin
          ptr_nxt_s = ptr_after(arb_idx_s);
        end else begin
          lock_nxt_s       = 1'b1;
          gidx_nxt_s       = arb_idx_s;
          beats_left_nxt_s = total_beats_s - BeatWidth'(1'b1);
        end
      end else if (dev_valid_o) begin
        lock_nxt_s       = 1'b1;
        gidx_nxt_s       = arb_idx_s;
        beats_left_nxt_s = total_beats_s;
      end else begin
        lock_nxt_s = 1'b0;
      end
    end else begin
      if (accept_s && beats_left_r == BeatWidth'(1'b1)) begin
        lock_nxt_s       = 1'b0;
        beats_left_nxt_s = '0;
        ptr_nxt_s        = ptr_after(gidx_r);
      end else if (accept_s) begin
        beats_left_nxt_s = beats_left_r - BeatWidth'(1'b1);
      end else begin
        lock_nxt_s = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_r       <= 1'b0;
      beats_left_r <= '0;
      ptr_r        <= '0;
      gidx_r       <= '0;
    end else begin
      lock_r       <= lock_nxt_s;
      beats_left_r <= beats_left_nxt_s;
      ptr_r        <= ptr_nxt_s;
      gidx_r       <= gidx_nxt_s;
    end
  end

endmodule

// File: tb/tb_muntjac_tl_a_arbiter.sv
// Self-checking bench for muntjac_tl_a_arbiter: directed scenarios plus a
// randomized run against a message-level reference model.
module tb_muntjac_tl_a_arbiter;

  localparam int N  = 4;
  localparam int AW = 56;
  localparam int DW = 64;
  localparam int SW = 4;
  localparam int ZW = 3;
  localparam int MW = DW / 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            hv;
  logic [N-1:0]            hready;
  logic [N-1:0][2:0]       hop, hpar;
  logic [N-1:0][ZW-1:0]    hsz;
  logic [N-1:0][SW-1:0]    hsrc;
  logic [N-1:0][AW-1:0]    haddr;
  logic [N-1:0][MW-1:0]    hmask;
  logic [N-1:0][DW-1:0]    hdata;
  logic                    dev_valid, dev_ready;
  logic [2:0]              dev_op, dev_par;
  logic [ZW-1:0]           dev_sz;
  logic [SW-1:0]           dev_src;
  logic [AW-1:0]           dev_addr;
  logic [MW-1:0]           dev_mask;
  logic [DW-1:0]           dev_data;
  logic [N-1:0]            grant;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state (message level)
  int m_ptr, m_owner, m_left;
  int has_msg [N];
  int hb      [N];

  always #5 clk = ~clk;

  muntjac_tl_a_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .host_valid_i   (hv),
    .host_ready_o   (hready),
    .host_opcode_i  (hop),
    .host_param_i   (hpar),
    .host_size_i    (hsz),
    .host_source_i  (hsrc),
    .host_address_i (haddr),
    .host_mask_i    (hmask),
    .host_data_i    (hdata),
    .dev_valid_o    (dev_valid),
    .dev_ready_i    (dev_ready),
    .dev_opcode_o   (dev_op),
    .dev_param_o    (dev_par),
    .dev_size_o     (dev_sz),
    .dev_source_o   (dev_src),
    .dev_address_o  (dev_addr),
    .dev_mask_o     (dev_mask),
    .dev_data_o     (dev_data),
    .grant_o        (grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hosts();
    hv = '0; hop = '0; hpar = '0; hsz = '0; hsrc = '0;
    haddr = '0; hmask = '0; hdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dev_ready = 1'b0;
    clear_hosts();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_host(input int h, input int op, input int sz);
    hv[h]    = 1'b1;
    hop[h]   = 3'(op);
    hpar[h]  = 3'($urandom_range(7, 0));
    hsz[h]   = ZW'(sz);
    hsrc[h]  = SW'(h * 3 + 1);
    haddr[h] = AW'({$urandom, $urandom});
    hmask[h] = MW'($urandom);
    hdata[h] = {$urandom, $urandom};
  endtask

  function automatic int msg_beats(input int op, input int sz);
    int b;
    if (op >= 4) return 1;
    b = (1 << sz) / MW;
    return (b < 1) ? 1 : b;
  endfunction

  function automatic int exp_grant();
    if (m_owner >= 0) return m_owner;
    for (int i = 0; i < N; i++) begin
      if (hv[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    #2;
    n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want %b", grant, 4'b0000); else n_pass++;
    n_checks++; if (dev_valid !== 1'b0) $display("FAIL reset_dev_valid: got %b want 0", dev_valid); else n_pass++;
    n_checks++; if (hready !== 4'b0000) $display("FAIL reset_host_ready: got %b want 0000", hready); else n_pass++;
  endtask

  task automatic test_two_hosts();
    do_reset();
    set_host(0, 4, 3);
    set_host(2, 4, 3);
    dev_ready = 1'b1;
    #2;
    n_checks++; if (grant !== 4'b0001) $display("FAIL two_c0_grant: got %b want 0001", grant); else n_pass++;
    n_checks++; if (dev_src !== hsrc[0]) $display("FAIL two_c0_source: got %h want %h", dev_src, hsrc[0]); else n_pass++;
    n_checks++; if (hready !== 4'b0001) $display("FAIL two_c0_ready: got %b want 0001", hready); else n_pass++;
    tick();
    hv[0] = 1'b0;
    #2;
    n_checks++; if (grant !== 4'b0100) $display("FAIL two_c1_grant: got %b want 0100", grant); else n_pass++;
    n_checks++; if (dev_addr !== haddr[2]) $display("FAIL two_c1_address: got %h want %h", dev_addr, haddr[2]); else n_pass++;
    tick();
    hv[2] = 1'b0;
    set_host(0, 4, 3);
    set_host(3, 4, 3);
    #2;
    n_checks++; if (grant !== 4'b1000) $display("FAIL two_ptr3_grant: got %b want 1000", grant); else n_pass++;
    tick();
  endtask

  task automatic test_rotation();
    logic [N-1:0] want;
    do_reset();
    for (int h = 0; h < N; h++) set_host(h, 4, 3);
    dev_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #2;
      want = 4'b0001 << (c % N);
      n_checks++; if (grant !== want) $display("FAIL rotation_grant c%0d: got %b want %b", c, grant, want); else n_pass++;
      n_checks++; if (dev_valid !== 1'b1) $display("FAIL rotation_valid c%0d: got %b want 1", c, dev_valid); else n_pass++;
      tick();
    end
  endtask

  task automatic test_burst();
    logic rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    set_host(1, 0, 5);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) set_host(0, 4, 3);
      dev_ready = rdy[c];
      #2;
      n_checks++; if (grant !== 4'b0010) $display("FAIL burst_grant c%0d: got %b want 0010", c, grant); else n_pass++;
      n_checks++; if (dev_src !== hsrc[1] || dev_addr !== haddr[1])
        $display("FAIL burst_payload c%0d: got %h/%h want %h/%h", c, dev_src, dev_addr, hsrc[1], haddr[1]);
      else n_pass++;
      n_checks++; if (hready[0] !== 1'b0) $display("FAIL burst_host0_ready c%0d: got %b want 0", c, hready[0]); else n_pass++;
      tick();
    end
    hv[1] = 1'b0;
    dev_ready = 1'b1;
    #2;
    n_checks++; if (grant !== 4'b0001) $display("FAIL burst_next_grant: got %b want 0001", grant); else n_pass++;
    tick();
  endtask

  task automatic test_hold();
    logic [AW-1:0] a3;
    do_reset();
    set_host(3, 4, 3);
    a3 = haddr[3];
    for (int c = 0; c < 4; c++) begin
      if (c == 1) set_host(0, 4, 3);
      dev_ready = (c == 3) ? 1'b1 : 1'b0;
      #2;
      n_checks++; if (grant !== 4'b1000) $display("FAIL hold_grant c%0d: got %b want 1000", c, grant); else n_pass++;
      n_checks++; if (dev_addr !== a3) $display("FAIL hold_address c%0d: got %h want %h", c, dev_addr, a3); else n_pass++;
      tick();
    end
    hv[3] = 1'b0;
    #2;
    n_checks++; if (grant !== 4'b0001) $display("FAIL hold_next_grant: got %b want 0001", grant); else n_pass++;
    tick();
  endtask

  task automatic test_sub_beat();
    do_reset();
    set_host(1, 1, 2);
    set_host(2, 4, 3);
    dev_ready = 1'b1;
    #2;
    n_checks++; if (grant !== 4'b0010) $display("FAIL subbeat_c0_grant: got %b want 0010", grant); else n_pass++;
    tick();
    set_host(1, 1, 2);
    #2;
    n_checks++; if (grant !== 4'b0100) $display("FAIL subbeat_c1_grant: got %b want 0100", grant); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_host(2, 0, 5);
    dev_ready = 1'b1;
    #2;
    n_checks++; if (grant !== 4'b0100) $display("FAIL rstburst_b1_grant: got %b want 0100", grant); else n_pass++;
    tick();
    #2;
    n_checks++; if (grant !== 4'b0100) $display("FAIL rstburst_b2_grant: got %b want 0100", grant); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_hosts();
    #2;
    n_checks++; if (grant !== 4'b0000) $display("FAIL rstburst_grant_after: got %b want 0000", grant); else n_pass++;
    n_checks++; if (dev_valid !== 1'b0) $display("FAIL rstburst_valid_after: got %b want 0", dev_valid); else n_pass++;
    set_host(0, 4, 3);
    set_host(2, 4, 3);
    #1;
    n_checks++; if (grant !== 4'b0001) $display("FAIL rstburst_rearb: got %b want 0001", grant); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int g;
    logic ev;
    logic [N-1:0] eg, er;
    do_reset();
    m_ptr = 0; m_owner = -1; m_left = 0;
    for (int h = 0; h < N; h++) begin has_msg[h] = 0; hb[h] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int h = 0; h < N; h++) begin
        if (has_msg[h] == 0 && $urandom_range(1, 0) == 1) begin
          set_host(h, $urandom_range(7, 0), $urandom_range(6, 0));
          has_msg[h] = 1;
          hb[h] = msg_beats(int'(hop[h]), int'(hsz[h]));
        end
        hv[h] = (has_msg[h] != 0) && ($urandom_range(3, 0) != 0);
      end
      dev_ready = ($urandom_range(3, 0) != 0);
      #2;
      g  = exp_grant();
      ev = (g < 0) ? 1'b0 : ((m_owner >= 0) ? hv[g] : 1'b1);
      eg = (g < 0) ? 4'b0000 : (4'b0001 << g);
      er = dev_ready ? eg : 4'b0000;
      n_checks++; if (grant !== eg) $display("FAIL rand_grant cyc%0d: got %b want %b", cyc, grant, eg); else n_pass++;
      n_checks++; if (dev_valid !== ev) $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, dev_valid, ev); else n_pass++;
      n_checks++; if (hready !== er) $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, hready, er); else n_pass++;
      if (ev) begin
        n_checks++;
        if (dev_src !== hsrc[g] || dev_addr !== haddr[g] || dev_data !== hdata[g] || dev_sz !== hsz[g])
          $display("FAIL rand_payload cyc%0d: got src %h addr %h want src %h addr %h", cyc, dev_src, dev_addr, hsrc[g], haddr[g]);
        else n_pass++;
      end
      if (g >= 0) begin
        if (m_owner < 0) begin
          m_owner = g;
          m_left  = msg_beats(int'(hop[g]), int'(hsz[g]));
        end
        if (ev && dev_ready) begin
          m_left--;
          hb[g]--;
          if (hb[g] == 0) has_msg[g] = 0;
          if (m_left == 0) begin
            m_owner = -1;
            m_ptr   = (g + 1) % N;
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    dev_ready = 1'b0;
    clear_hosts();
    tick();
    test_reset();
    test_two_hosts();
    test_rotation();
    test_burst();
    test_hold();
    test_sub_beat();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
